// File: rtl/regfile_write_arbiter.sv
// Two-port writeback arbiter for the register bank's single write port.
// Port A has fixed priority; an aging counter bounds how long port B can be starved.
module regfile_write_arbiter #(
    parameter int n       = 32,
    parameter int MAXWAIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    input  logic [4:0]   a_addr,
    input  logic [n-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [4:0]   b_addr,
    input  logic [n-1:0] b_data,
    output logic         b_ready,
    output logic         wr_load,
    output logic [4:0]   wr_addr,
    output logic [n-1:0] wr_data,
    output logic         b_boost
);

    localparam logic [3:0] MAX_CNT = 4'(MAXWAIT);

    logic [3:0] wait_cnt;
    logic       a_fire;
    logic       b_fire;

    // Ready depends only on the other port's valid, never on its own.
    always_comb begin
        b_boost = (wait_cnt == MAX_CNT);
        a_ready = !(b_valid && b_boost);
        b_ready = !a_valid || b_boost;
        a_fire  = a_valid && a_ready;
        b_fire  = b_valid && b_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (b_valid && !b_ready) begin
            if (wait_cnt != MAX_CNT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // x0 writes are accepted but never reach the bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_load <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (a_fire) begin
            wr_load <= (a_addr != '0);
            wr_addr <= a_addr;
            wr_data <= a_data;
        end else if (b_fire) begin
            wr_load <= (b_addr != '0);
            wr_addr <= b_addr;
            wr_data <= b_data;
        end else begin
            wr_load <= 1'b0;
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the register bank between two writeback requesters: port A (memory/load writeback) and port B (ALU writeback). The bank is 32 address-gated registers, each loading on `load && addr == ref_addr`. Port A has fixed priority. An aging counter guarantees port B a grant after at most `MAXWAIT` lost cycles. Winning writes are registered and driven to the bank's `load`/`addr`/`D` inputs one cycle later, and writes to x0 are accepted and silently discarded.

## Interface

Parameters:
- `n`, 32, data width of a register
- `MAXWAIT`, 3, maximum consecutive cycles port B may lose arbitration while valid; legal range 1..15

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `a_valid`  in  1  port A write request
- `a_addr`  in  5  port A destination register
- `a_data`  in  n  port A write data
- `a_ready`  out  1  port A request accepted this cycle
- `b_valid`  in  1  port B write request
- `b_addr`  in  5  port B destination register
- `b_data`  in  n  port B write data
- `b_ready`  out  1  port B request accepted this cycle
- `wr_load`  out  1  bank write enable
- `wr_addr`  out  5  bank write address (the bank's `addr`)
- `wr_data`  out  n  bank write data (the bank's `D`)
- `b_boost`  out  1  high while `wait_cnt == MAXWAIT`, i.e. port B holds priority this cycle

## Operation

- Internal state is `wait_cnt`, 4 bits, saturating at `MAXWAIT`.
- Priority is combinational from the current state:
  - `b_boost = (wait_cnt == MAXWAIT)`
  - `a_ready = !(b_valid && b_boost)`
  - `b_ready = !a_valid || b_boost`
- A port transfers ("fires") when `valid && ready`. At most one port fires per cycle.
- The requester must hold `addr`/`data` stable while `valid` is high and `ready` is low.
- Aging counter, updated at each edge:
  - If `b_valid && !b_ready`, `wait_cnt` increments, saturating at `MAXWAIT`.
  - If `b_fire` or `!b_valid`, `wait_cnt` clears to 0.
  - If `b_valid` drops while waiting, the count is lost; B gets no credit.
- Output register, updated at each edge:
  - `wr_addr` and `wr_data` take the firing port's address and data.
  - `wr_load = 1` only if a port fired and its address is non-zero.
  - If no port fires, `wr_load = 0` and `wr_addr`/`wr_data` hold their previous values.
- x0: the request is accepted (`ready` high, counter behaves as for a normal fire) but no write is issued, so `wr_load = 0`.
- Same-address requests on A and B are ordered by the arbiter. The later-granted write lands last and wins in the bank. No merging or cancellation.

## Timing

- Reset (`rst` low, asynchronous) forces `wait_cnt = 0`, `wr_load = 0`, `wr_addr = 0`, `wr_data = 0`.
- `a_ready`/`b_ready` follow the reset state combinationally: `b_boost = 0`, `a_ready = 1`, `b_ready = !a_valid`.
- Reset asserted mid-operation drops any registered write not yet seen by the bank. The bank resets on the same `rst`, so this is consistent.
- Latency is 1 cycle: a fire in cycle k gives `wr_load`/`wr_addr`/`wr_data` valid in cycle k+1, and the bank captures them at the end of k+1.
- Throughput is one accepted write per cycle.
- Worst-case B wait with A continuously valid is exactly `MAXWAIT` cycles: B fires in the (`MAXWAIT`+1)-th cycle of its request.
- While `b_boost` is high and B is valid, A is stalled for exactly that cycle. `wait_cnt` then returns to 0, so A wins again the next cycle.
- `ready` outputs depend combinationally on the other port's `valid`, never on their own `valid`. There is no combinational path from `wr_*` to the inputs.

## Test plan

- **Reset:** drive `rst = 0` with random inputs, then release with all `valid` low. Required: `wr_load = 0`, `wr_addr = 0`, `wr_data = 0`, `b_boost = 0`, `a_ready = 1`, `b_ready = 1`.
- **Single A write:** `a_valid = 1`, `a_addr = 5`, `a_data = 0xDEADBEEF` for one cycle. Required: `a_ready = 1` that cycle; next cycle `wr_load = 1`, `wr_addr = 5`, `wr_data = 0xDEADBEEF`; the cycle after, `wr_load = 0`.
- **Aging, `MAXWAIT = 3`:** A continuously valid (addr 1, 2, 3...); B valid from cycle 0 with addr 9, data 0x1234. Required:
  - `b_ready = 0` in cycles 0–2.
  - `b_boost = 1`, `b_ready = 1`, `a_ready = 0` in cycle 3.
  - `wr_addr = 9` and `wr_data = 0x1234` in cycle 4.
  - `a_ready = 1` again in cycle 4.
- **x0 discard:** B alone writes addr 0, data 0xFFFFFFFF. Required: `b_ready = 1`; next cycle `wr_load = 0` and the bank is unchanged.
- **Same-address ordering:** A (addr 7, data 0x11) and B (addr 7, data 0x22) both valid with `wait_cnt = 0`. Required: A fires first, B fires later, and after the `wr_*` pipeline drains, bank entry 7 holds 0x22.
- **Reset mid-wait:** assert `rst` while `wait_cnt = 2`. Required: `wait_cnt` and `wr_load` clear immediately, and after release B needs another full 3 lost cycles before boost.
